rob: RTL and testbench
======================

Name: rob

Overview:
- Reorder buffer: circular queue of in-flight instructions, indexed by ROB tag (physical address).
- Allocates a tag at dispatch and captures execution writebacks out of order.
- Retires entries in program order and drives the allocate/commit/flush interface consumed by the register alias table.
- Also serves operand values for entries that have completed but not yet retired.

Parameters:
- ROB_DEPTH, 8, number of entries; power of two, at least 2.
- GPR_ADDR_WIDTH, 5, architectural register address width.
- DATA_WIDTH, 32, result width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- alloc_req  in  1  dispatch requests an entry.
- alloc_dst_addr  in  GPR_ADDR_WIDTH  destination architectural register.
- alloc_dst_wen  in  1  instruction writes a GPR.
- alloc_ready  out  1  entry available (count < ROB_DEPTH).
- allocate_en  out  1  allocation accepted this cycle.
- rob_alloc_tag_2rat  out  $clog2(ROB_DEPTH)  tag allocated (tail pointer).
- rob_alloc_dst_addr_2rat  out  GPR_ADDR_WIDTH  pass-through of alloc_dst_addr.
- rob_alloc_dst_wen_2rat  out  1  pass-through of alloc_dst_wen.
- wb_en  in  1  execution writeback valid.
- wb_tag  in  $clog2(ROB_DEPTH)  entry being completed.
- wb_data  in  DATA_WIDTH  result.
- wb_br_taken  in  1  entry is a mispredicted/taken branch requiring flush.
- wb_exp  in  1  entry raised an exception.
- rd1_tag, rd2_tag  in  $clog2(ROB_DEPTH)  operand lookup tags.
- rd1_ready, rd2_ready  out  1  looked-up entry has its result.
- rd1_data, rd2_data  out  DATA_WIDTH  looked-up result.
- commit_en  out  1  head entry retires this cycle.
- rob_commit_dst_addr_2rat  out  GPR_ADDR_WIDTH  head destination; 0 when head dst_wen = 0.
- rob_commit_dst_wen  out  1  head writes a GPR.
- rob_commit_data  out  DATA_WIDTH  head result, for the register file.
- rob_commit_br_taken  out  1  retiring entry has the taken flag.
- rob_commit_exp_en  out  1  retiring entry has the exception flag.

Behaviour:
- State:
  - per entry: valid, done, dst_addr, dst_wen, data, br_taken, exp.
  - head_ptr, tail_ptr: $clog2(ROB_DEPTH) bits.
  - count: $clog2(ROB_DEPTH)+1 bits.
- Reset (rst = 1, asynchronous):
  - all entry state, pointers and count cleared to 0.
  - all outputs 0 except rob_alloc_tag_2rat = 0 and alloc_ready = 1.
- flush = commit_en & (head br_taken | head exp). All outputs are combinational from registered state and inputs.
- Allocate:
  - allocate_en = alloc_req & alloc_ready & ~flush.
  - alloc_ready ignores a same-cycle commit, so a full ROB with a commit pending still reports 0.
  - At the edge: entry[tail] gets valid = 1, done = 0, br_taken = 0, exp = 0, and captures dst_addr/dst_wen. tail_ptr increments, wrapping ROB_DEPTH-1 -> 0.
- Writeback:
  - Taken when wb_en and entry[wb_tag].valid.
  - At the edge: done = 1; data, br_taken and exp captured.
  - Writeback to an invalid entry is ignored. A writeback to an entry already done overwrites it (no protection).
- Commit:
  - commit_en = entry[head].valid & entry[head].done, with 1-cycle minimum latency from writeback.
  - At the edge: entry[head].valid cleared, head_ptr increments with wrap, count decrements.
  - At most one commit per cycle.
- Flush:
  - On the edge where flush = 1, every entry's valid/done is cleared and head_ptr = tail_ptr = count = 0.
  - Allocation is suppressed that cycle. Writeback is discarded that cycle.
  - The RAT clears on the same edge from rob_commit_br_taken / rob_commit_exp_en.
- Simultaneous events:
  - alloc + commit, no flush: count unchanged.
  - Alloc into a slot freed by the same-cycle commit is impossible, because alloc_ready ignores the commit.
- Operand read:
  - rdN_ready = entry[rdN_tag].valid & (entry.done | (wb_en & wb_tag == rdN_tag)).
  - rdN_data = wb_data on a bypass hit, else entry data.
  - When not ready, rdN_data = 0.
- Empty: commit_en = 0 and all commit outputs 0.
- Full: count == ROB_DEPTH, alloc_ready = 0, head_ptr == tail_ptr.

Test Plan:
- Reset then allocate 3 entries (dst x1, x2, x3, wen = 1) -> tags 0, 1, 2 with allocate_en each cycle; count = 3; commit_en stays 0.
- Writeback out of order (tag 2 data 0x33, then tag 0 data 0x11, then tag 1 data 0x22) -> commits occur in order x1 = 0x11, x2 = 0x22, x3 = 0x33, one per cycle, with commit_en rising the cycle after tag 0's writeback.
- Fill 8 entries -> alloc_ready = 0 and a 9th request gives allocate_en = 0. Commit one -> next cycle alloc_ready = 1 and the new tag is 0 (wrap).
- Entry 1 written back with wb_br_taken = 1 while entries 2–4 are pending and alloc_req = 1 in the commit cycle -> rob_commit_br_taken = 1 and allocate_en = 0 that cycle. Next cycle count = 0 and the next allocated tag is 0.
- rd1_tag = 3 in the same cycle as wb_en, tag 3, data 0xABCD -> rd1_ready = 1 and rd1_data = 0xABCD combinationally. A store entry (dst_wen = 0, dst_addr = 7) commits with rob_commit_dst_addr_2rat = 0.
- Assert rst mid-stream with 5 entries valid -> outputs clear immediately (asynchronous); after release the first allocation returns tag 0.

Source files
------------

// File: rtl/rob.sv
// Reorder buffer: circular queue of in-flight instructions indexed by tag. Allocates at
// dispatch, captures out-of-order writebacks, retires in order and flushes on branch/exception.
module rob #(
    parameter int unsigned ROB_DEPTH      = 8,
    parameter int unsigned GPR_ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH     = 32,
    localparam int unsigned TagW          = $clog2(ROB_DEPTH),
    localparam int unsigned CntW          = TagW + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alloc_req,
    input  logic [GPR_ADDR_WIDTH-1:0] alloc_dst_addr,
    input  logic                      alloc_dst_wen,
    output logic                      alloc_ready,
    output logic                      allocate_en,
    output logic [TagW-1:0]           rob_alloc_tag_2rat,
    output logic [GPR_ADDR_WIDTH-1:0] rob_alloc_dst_addr_2rat,
    output logic                      rob_alloc_dst_wen_2rat,
    input  logic                      wb_en,
    input  logic [TagW-1:0]           wb_tag,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    input  logic                      wb_br_taken,
    input  logic                      wb_exp,
    input  logic [TagW-1:0]           rd1_tag,
    input  logic [TagW-1:0]           rd2_tag,
    output logic                      rd1_ready,
    output logic                      rd2_ready,
    output logic [DATA_WIDTH-1:0]     rd1_data,
    output logic [DATA_WIDTH-1:0]     rd2_data,
    output logic                      commit_en,
    output logic [GPR_ADDR_WIDTH-1:0] rob_commit_dst_addr_2rat,
    output logic                      rob_commit_dst_wen,
    output logic [DATA_WIDTH-1:0]     rob_commit_data,
    output logic                      rob_commit_br_taken,
    output logic                      rob_commit_exp_en
);

    logic [ROB_DEPTH-1:0]      valid_q;
    logic [ROB_DEPTH-1:0]      done_q;
    logic [ROB_DEPTH-1:0]      dst_wen_q;
    logic [ROB_DEPTH-1:0]      br_taken_q;
    logic [ROB_DEPTH-1:0]      exp_q;
    logic [GPR_ADDR_WIDTH-1:0] dst_addr_q [ROB_DEPTH];
    logic [DATA_WIDTH-1:0]     data_q     [ROB_DEPTH];
    logic [TagW-1:0]           head_q, tail_q;
    logic [CntW-1:0]           count_q, count_d;

    logic flush;
    logic wb_take;

    // Full check deliberately ignores a same-cycle commit.
    assign alloc_ready = (count_q != CntW'(ROB_DEPTH));
    assign commit_en   = valid_q[head_q] & done_q[head_q];
    assign flush       = commit_en & (br_taken_q[head_q] | exp_q[head_q]);
    assign allocate_en = alloc_req & alloc_ready & ~flush;
    assign wb_take     = wb_en & valid_q[wb_tag] & ~flush;

    assign rob_alloc_tag_2rat      = tail_q;
    assign rob_alloc_dst_addr_2rat = alloc_dst_addr;
    assign rob_alloc_dst_wen_2rat  = alloc_dst_wen;

    assign rob_commit_dst_wen       = commit_en & dst_wen_q[head_q];
    assign rob_commit_dst_addr_2rat = rob_commit_dst_wen ? dst_addr_q[head_q] : '0;
    assign rob_commit_data          = commit_en ? data_q[head_q] : '0;
    assign rob_commit_br_taken      = commit_en & br_taken_q[head_q];
    assign rob_commit_exp_en        = commit_en & exp_q[head_q];

    // Operand lookup, bypassing a writeback landing this cycle.
    always_comb begin
        rd1_ready = valid_q[rd1_tag] & (done_q[rd1_tag] | (wb_en & (wb_tag == rd1_tag)));
        rd2_ready = valid_q[rd2_tag] & (done_q[rd2_tag] | (wb_en & (wb_tag == rd2_tag)));
        rd1_data  = '0;
        rd2_data  = '0;
        if (rd1_ready) begin
            rd1_data = (wb_en && wb_tag == rd1_tag) ? wb_data : data_q[rd1_tag];
        end
        if (rd2_ready) begin
            rd2_data = (wb_en && wb_tag == rd2_tag) ? wb_data : data_q[rd2_tag];
        end
    end

    assign count_d = count_q + CntW'(allocate_en) - CntW'(commit_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= '0;
            done_q     <= '0;
            dst_wen_q  <= '0;
            br_taken_q <= '0;
            exp_q      <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                dst_addr_q[i] <= '0;
                data_q[i]     <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (wb_take) begin
                done_q[wb_tag]     <= 1'b1;
                data_q[wb_tag]     <= wb_data;
                br_taken_q[wb_tag] <= wb_br_taken;
                exp_q[wb_tag]      <= wb_exp;
            end
            if (commit_en) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            // Allocation never targets a valid slot, so it cannot collide with wb or commit.
            if (allocate_en) begin
                valid_q[tail_q]    <= 1'b1;
                done_q[tail_q]     <= 1'b0;
                br_taken_q[tail_q] <= 1'b0;
                exp_q[tail_q]      <= 1'b0;
                dst_addr_q[tail_q] <= alloc_dst_addr;
                dst_wen_q[tail_q]  <= alloc_dst_wen;
                tail_q             <= tail_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_rob.sv
// Directed self-checking bench for the reorder buffer: in-order retire, full/wrap,
// flush on branch/exception, operand bypass, store commit and asynchronous reset.
module tb_rob;

    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_req;
    logic [4:0]  alloc_dst_addr;
    logic        alloc_dst_wen;
    logic        alloc_ready;
    logic        allocate_en;
    logic [2:0]  rob_alloc_tag_2rat;
    logic [4:0]  rob_alloc_dst_addr_2rat;
    logic        rob_alloc_dst_wen_2rat;
    logic        wb_en;
    logic [2:0]  wb_tag;
    logic [31:0] wb_data;
    logic        wb_br_taken;
    logic        wb_exp;
    logic [2:0]  rd1_tag, rd2_tag;
    logic        rd1_ready, rd2_ready;
    logic [31:0] rd1_data, rd2_data;
    logic        commit_en;
    logic [4:0]  rob_commit_dst_addr_2rat;
    logic        rob_commit_dst_wen;
    logic [31:0] rob_commit_data;
    logic        rob_commit_br_taken;
    logic        rob_commit_exp_en;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rob dut (
        .clk                      (clk),
        .rst                      (rst),
        .alloc_req                (alloc_req),
        .alloc_dst_addr           (alloc_dst_addr),
        .alloc_dst_wen            (alloc_dst_wen),
        .alloc_ready              (alloc_ready),
        .allocate_en              (allocate_en),
        .rob_alloc_tag_2rat       (rob_alloc_tag_2rat),
        .rob_alloc_dst_addr_2rat  (rob_alloc_dst_addr_2rat),
        .rob_alloc_dst_wen_2rat   (rob_alloc_dst_wen_2rat),
        .wb_en                    (wb_en),
        .wb_tag                   (wb_tag),
        .wb_data                  (wb_data),
        .wb_br_taken              (wb_br_taken),
        .wb_exp                   (wb_exp),
        .rd1_tag                  (rd1_tag),
        .rd2_tag                  (rd2_tag),
        .rd1_ready                (rd1_ready),
        .rd2_ready                (rd2_ready),
        .rd1_data                 (rd1_data),
        .rd2_data                 (rd2_data),
        .commit_en                (commit_en),
        .rob_commit_dst_addr_2rat (rob_commit_dst_addr_2rat),
        .rob_commit_dst_wen       (rob_commit_dst_wen),
        .rob_commit_data          (rob_commit_data),
        .rob_commit_br_taken      (rob_commit_br_taken),
        .rob_commit_exp_en        (rob_commit_exp_en)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_req = 1'b0; alloc_dst_addr = '0; alloc_dst_wen = 1'b0;
        wb_en = 1'b0; wb_tag = '0; wb_data = '0; wb_br_taken = 1'b0; wb_exp = 1'b0;
    endtask

    task automatic alloc(input logic [4:0] dst, input logic wen);
        idle();
        alloc_req = 1'b1; alloc_dst_addr = dst; alloc_dst_wen = wen;
    endtask

    task automatic wb(input logic [2:0] tag, input logic [31:0] data, input logic br,
                      input logic ex);
        idle();
        wb_en = 1'b1; wb_tag = tag; wb_data = data; wb_br_taken = br; wb_exp = ex;
    endtask

    initial begin
        rst = 1'b1; rd1_tag = '0; rd2_tag = '0;
        idle();
        #2;
        check("rst_alloc_ready", 32'(alloc_ready), 1);
        check("rst_commit_en", 32'(commit_en), 0);
        check("rst_tag", 32'(rob_alloc_tag_2rat), 0);
        check("rst_rd1_ready", 32'(rd1_ready), 0);
        @(posedge clk); #2; rst = 1'b0; #1;

        // Allocate x1..x3 -> tags 0..2
        for (int i = 0; i < 3; i++) begin
            alloc(5'(i + 1), 1'b1); #1;
            check("alloc3_en", 32'(allocate_en), 1);
            check("alloc3_tag", 32'(rob_alloc_tag_2rat), i);
            check("alloc3_pass_addr", 32'(rob_alloc_dst_addr_2rat), i + 1);
            check("alloc3_no_commit", 32'(commit_en), 0);
            tick();
        end
        idle(); #1;
        check("alloc3_count", 32'(dut.count_q), 3);

        // Out-of-order writeback, in-order retire
        wb(3'd2, 32'h33, 1'b0, 1'b0); #1;
        check("ooo_no_commit_t2", 32'(commit_en), 0);
        tick();
        wb(3'd0, 32'h11, 1'b0, 1'b0); #1;
        check("ooo_no_commit_t0", 32'(commit_en), 0);
        tick();
        wb(3'd1, 32'h22, 1'b0, 1'b0); #1;
        check("retire0_en", 32'(commit_en), 1);
        check("retire0_addr", 32'(rob_commit_dst_addr_2rat), 1);
        check("retire0_data", rob_commit_data, 32'h11);
        check("retire0_wen", 32'(rob_commit_dst_wen), 1);
        tick();
        idle(); #1;
        check("retire1_addr", 32'(rob_commit_dst_addr_2rat), 2);
        check("retire1_data", rob_commit_data, 32'h22);
        tick();
        check("retire2_addr", 32'(rob_commit_dst_addr_2rat), 3);
        check("retire2_data", rob_commit_data, 32'h33);
        tick();
        check("drained_commit_en", 32'(commit_en), 0);
        check("drained_commit_data", rob_commit_data, 0);
        check("drained_count", 32'(dut.count_q), 0);

        // Flush on taken branch: tags 3..6 allocated, tag 3 taken, alloc blocked
        for (int i = 0; i < 4; i++) begin
            alloc(5'(i + 4), 1'b1); #1;
            check("fl_alloc_tag", 32'(rob_alloc_tag_2rat), i + 3);
            tick();
        end
        wb(3'd3, 32'h44, 1'b1, 1'b0); tick();
        alloc(5'd9, 1'b1); #1;
        check("fl_commit_en", 32'(commit_en), 1);
        check("fl_br_taken", 32'(rob_commit_br_taken), 1);
        check("fl_exp", 32'(rob_commit_exp_en), 0);
        check("fl_alloc_ready", 32'(alloc_ready), 1);
        check("fl_alloc_blocked", 32'(allocate_en), 0);
        tick();
        idle(); #1;
        check("fl_count", 32'(dut.count_q), 0);
        check("fl_commit_after", 32'(commit_en), 0);
        check("fl_next_tag", 32'(rob_alloc_tag_2rat), 0);

        // Fill 8, full behaviour, wrap
        for (int i = 0; i < 8; i++) begin
            alloc(5'(i + 10), 1'b1); #1;
            check("fill_en", 32'(allocate_en), 1);
            check("fill_tag", 32'(rob_alloc_tag_2rat), i);
            tick();
        end
        alloc(5'd20, 1'b1); #1;
        check("full_ready", 32'(alloc_ready), 0);
        check("full_9th_en", 32'(allocate_en), 0);
        wb(3'd0, 32'h100, 1'b0, 1'b0); alloc_req = 1'b1; #1;
        check("full_wb_ready", 32'(alloc_ready), 0);
        tick();
        check("full_commit_en", 32'(commit_en), 1);
        check("full_commit_ready", 32'(alloc_ready), 0);
        check("full_commit_alloc", 32'(allocate_en), 0);
        check("full_commit_data", rob_commit_data, 32'h100);
        tick();
        alloc(5'd21, 1'b1); #1;
        check("wrap_ready", 32'(alloc_ready), 1);
        check("wrap_en", 32'(allocate_en), 1);
        check("wrap_tag", 32'(rob_alloc_tag_2rat), 0);
        tick();
        idle(); #1;
        check("refull_ready", 32'(alloc_ready), 0);

        // Exception on head (tag 1) flushes a full ROB
        wb(3'd1, 32'h55, 1'b0, 1'b1); tick();
        idle(); #1;
        check("exp_en", 32'(rob_commit_exp_en), 1);
        check("exp_br", 32'(rob_commit_br_taken), 0);
        tick();
        check("exp_count", 32'(dut.count_q), 0);
        check("exp_ready", 32'(alloc_ready), 1);

        // Bypass read and store commit: tag 0 is a store to x7, tags 1..3 write x9
        alloc(5'd7, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            alloc(5'd9, 1'b1); tick();
        end
        idle(); rd1_tag = 3'd3; rd2_tag = 3'd5; #1;
        check("rd1_not_ready", 32'(rd1_ready), 0);
        check("rd1_not_ready_data", rd1_data, 0);
        check("rd2_invalid", 32'(rd2_ready), 0);
        wb(3'd3, 32'hABCD, 1'b0, 1'b0); rd2_tag = 3'd0; #1;
        check("byp_ready", 32'(rd1_ready), 1);
        check("byp_data", rd1_data, 32'hABCD);
        check("byp_other_ready", 32'(rd2_ready), 0);
        tick();
        wb(3'd0, 32'h77, 1'b0, 1'b0); #1;
        check("stored_ready", 32'(rd1_ready), 1);
        check("stored_data", rd1_data, 32'hABCD);
        tick();
        idle(); #1;
        check("store_commit_en", 32'(commit_en), 1);
        check("store_addr_zero", 32'(rob_commit_dst_addr_2rat), 0);
        check("store_wen", 32'(rob_commit_dst_wen), 0);
        check("store_data", rob_commit_data, 32'h77);
        check("rd2_done_data", rd2_data, 32'h77);
        tick();

        // Mid-stream async reset with 5 entries valid and a commit pending
        alloc(5'd12, 1'b1); tick();
        alloc(5'd13, 1'b1); tick();
        wb(3'd1, 32'h99, 1'b0, 1'b0); tick();
        idle(); #1;
        check("pre_rst_count", 32'(dut.count_q), 5);
        check("pre_rst_commit", 32'(commit_en), 1);
        rst = 1'b1; #1;
        check("arst_commit_en", 32'(commit_en), 0);
        check("arst_commit_data", rob_commit_data, 0);
        check("arst_tag", 32'(rob_alloc_tag_2rat), 0);
        check("arst_ready", 32'(alloc_ready), 1);
        check("arst_rd1", 32'(rd1_ready), 0);
        tick(); #2;
        rst = 1'b0;
        alloc(5'd1, 1'b1); #1;
        check("post_rst_en", 32'(allocate_en), 1);
        check("post_rst_tag", 32'(rob_alloc_tag_2rat), 0);
        tick();
        idle(); #1;
        check("post_rst_tag_next", 32'(rob_alloc_tag_2rat), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
